// File: rtl/snes_pad_responder.sv
// Controller side of the SNES joypad port: standard pad or 4-player multitap.
// The console's latch/clock/select are answered with registered serial data on D0/D1.

module snes_pad_lane #(
  parameter logic [3:0] ID_BITS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [11:0] pad,
  output logic        sr_lsb
);
  logic [15:0] sr;

  // Wire level is active-low, so pressed buttons and ID bits load inverted.
  always_ff @(posedge clk) begin
    if (reset)      sr <= 16'hFFFF;
    else if (load)  sr <= {~ID_BITS, ~pad};
    else if (shift) sr <= {1'b0, sr[15:1]};
  end

  assign sr_lsb = sr[0];
endmodule

module snes_pad_responder #(
  parameter logic [3:0] ID_BITS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtap_en,
  input  logic [11:0] pad_a,
  input  logic [11:0] pad_b,
  input  logic [11:0] pad_c,
  input  logic [11:0] pad_d,
  input  logic        joy_strb,
  input  logic        joy_clk,
  input  logic        joy_p6,
  output logic [1:0]  joy_di,
  output logic [4:0]  bit_cnt
);
  localparam int NUM_LANES = 2;

  logic                       clk_q;
  logic                       shift;
  logic                       bank_lo;
  logic [NUM_LANES-1:0][11:0] lane_pad;
  logic [NUM_LANES-1:0]       lane_lsb;

  // Low bank (pads 4/5) only exists on the multitap with IO select low.
  assign bank_lo     = mtap_en & ~joy_p6;
  assign lane_pad[0] = bank_lo ? pad_c : pad_a;
  assign lane_pad[1] = bank_lo ? pad_d : pad_b;
  assign shift       = ~clk_q & joy_clk & ~joy_strb;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    snes_pad_lane #(.ID_BITS(ID_BITS)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (joy_strb),
      .shift  (shift),
      .pad    (lane_pad[l]),
      .sr_lsb (lane_lsb[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_q   <= 1'b1;
      bit_cnt <= 5'd0;
      joy_di  <= 2'b11;
    end else begin
      clk_q <= joy_clk;
      if (joy_strb)                    bit_cnt <= 5'd0;
      else if (shift && bit_cnt != 16) bit_cnt <= bit_cnt + 5'd1;
      joy_di[0] <= lane_lsb[0];
      // D1 held low during latch is how the console detects a multitap.
      if (!mtap_en)     joy_di[1] <= 1'b1;
      else if (joy_strb) joy_di[1] <= 1'b0;
      else               joy_di[1] <= lane_lsb[1];
    end
  end
endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: full reads in single and multitap modes,
// strobe tracking, saturation and mid-read reset.

module tb_snes_pad_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        mtap_en;
  logic [11:0] pad_a, pad_b, pad_c, pad_d;
  logic        joy_strb, joy_clk, joy_p6;
  logic [1:0]  joy_di;
  logic [4:0]  bit_cnt;

  int vectors = 0;
  int miscompares = 0;

  snes_pad_responder #(.ID_BITS(4'b0000)) dut (
    .clk(clk), .reset(reset), .mtap_en(mtap_en),
    .pad_a(pad_a), .pad_b(pad_b), .pad_c(pad_c), .pad_d(pad_d),
    .joy_strb(joy_strb), .joy_clk(joy_clk), .joy_p6(joy_p6),
    .joy_di(joy_di), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rise();
    joy_clk = 1'b0; step(2);
    joy_clk = 1'b1; step(2);
  endtask

  task automatic latch();
    joy_strb = 1'b1; step(2);
    joy_strb = 1'b0; step(2);
  endtask

  // Reads 16 bits plus two extra rises; e0/e1 are wire-level words, bit n = n-th bit read.
  task automatic read_word(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic d1_after, input bit tog_p6);
    latch();
    for (int n = 0; n < 16; n++) begin
      if (n > 0) rise();
      chk($sformatf("%s D0 bit%0d", tag, n), joy_di[0], e0[n]);
      chk($sformatf("%s D1 bit%0d", tag, n), joy_di[1], e1[n]);
      chk($sformatf("%s cnt bit%0d", tag, n), bit_cnt, n);
      if (tog_p6 && n == 8) joy_p6 = ~joy_p6;
    end
    for (int k = 16; k < 18; k++) begin
      rise();
      chk($sformatf("%s D0 past%0d", tag, k), joy_di[0], 1'b0);
      chk($sformatf("%s D1 past%0d", tag, k), joy_di[1], d1_after);
      chk($sformatf("%s cnt sat%0d", tag, k), bit_cnt, 5'd16);
    end
  endtask

  initial begin
    reset = 1'b1; mtap_en = 1'b0; joy_strb = 1'b0; joy_clk = 1'b1; joy_p6 = 1'b1;
    pad_a = 12'h000; pad_b = 12'h000; pad_c = 12'h000; pad_d = 12'h000;
    step(2);
    chk("reset joy_di", joy_di, 2'b11);
    chk("reset bit_cnt", bit_cnt, 5'd0);
    reset = 1'b0; step(1);
    chk("post-reset joy_di", joy_di, 2'b11);

    // Single pad, B pressed
    pad_a = 12'h001;
    read_word("single B", 16'hFFFE, 16'hFFFF, 1'b1, 1'b0);

    // Single pad, all buttons, standard-pad ID
    pad_a = 12'hFFF;
    read_word("single all", 16'hF000, 16'hFFFF, 1'b1, 1'b0);

    // Multitap high bank: signature low during latch
    mtap_en = 1'b1; joy_p6 = 1'b1; pad_a = 12'h100; pad_b = 12'h002;
    joy_strb = 1'b1; step(2);
    chk("mtap strobe D1 sig", joy_di[1], 1'b0);
    joy_strb = 1'b0; step(2);
    read_word("mtap hi", 16'hFEFF, 16'hFFFD, 1'b0, 1'b0);

    // Multitap low bank, IO select toggled mid-read must not disturb stream
    joy_p6 = 1'b0; pad_c = 12'h010; pad_d = 12'h800;
    read_word("mtap lo", 16'hFFEF, 16'hF7FF, 1'b0, 1'b1);

    // mtap_en drop mid-stream: D1 goes high next cycle
    mtap_en = 1'b0; step(1);
    chk("mtap_en drop D1", joy_di[1], 1'b1);

    // Strobe tracking: pad change while latched, clock rises ignored
    joy_p6 = 1'b1; pad_a = 12'h000;
    joy_strb = 1'b1; step(2);
    chk("strb track before", joy_di[0], 1'b1);
    pad_a = 12'h001; step(1);
    chk("strb track 1cyc", joy_di[0], 1'b1);
    step(1);
    chk("strb track 2cyc", joy_di[0], 1'b0);
    joy_clk = 1'b0; step(2); joy_clk = 1'b1; step(2);
    chk("strb clk ignored cnt", bit_cnt, 5'd0);
    chk("strb clk ignored D0", joy_di[0], 1'b0);
    joy_strb = 1'b0; step(2);
    chk("strb release bit0", joy_di[0], 1'b0);
    rise();
    chk("strb release bit1", joy_di[0], 1'b1);
    chk("strb release cnt", bit_cnt, 5'd1);

    // Reset mid-read
    latch();
    repeat (5) rise();
    chk("pre-reset cnt", bit_cnt, 5'd5);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("mid reset cnt", bit_cnt, 5'd0);
    chk("mid reset joy_di", joy_di, 2'b11);
    step(1);
    read_word("after reset", 16'hFFFE, 16'hFFFF, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
